// File: rtl/irrigation_countdown_timer_if.sv
// Control and display signals of the irrigation countdown timer.
// The master side drives the controls. The slave (timer) side drives status and display.
interface irrigation_countdown_timer_if;
  logic [1:0] level;
  logic       start;
  logic       pause;
  logic       abort;
  logic [1:0] state;
  logic       valve_en;
  logic       done;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [6:0] seg;
  logic [3:0] dig_en;

  modport master (
    output level, start, pause, abort,
    input  state, valve_en, done, min_bcd, sec_bcd, seg, dig_en
  );

  modport slave (
    input  level, start, pause, abort,
    output state, valve_en, done, min_bcd, sec_bcd, seg, dig_en
  );
endinterface

// File: rtl/irrigation_countdown_timer.sv
// MM:SS countdown with moisture-selected presets, pause/abort, done pulse and 4-digit scanned 7-seg.
// Latency: controls act on the sampling edge. No backpressure: outputs are free-running status.
module irrigation_countdown_timer #(
  parameter int TICK_DIV       = 50_000_000,
  parameter int SCAN_DIV       = 50_000,
  parameter int PRESET_LOW     = 4,
  parameter int PRESET_MED     = 8,
  parameter int PRESET_HIGH    = 12,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  irrigation_countdown_timer_if.slave  tmr
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [7:0] LOW_BCD  = 8'(((PRESET_LOW  / 10) << 4) | (PRESET_LOW  % 10));
  localparam logic [7:0] MED_BCD  = 8'(((PRESET_MED  / 10) << 4) | (PRESET_MED  % 10));
  localparam logic [7:0] HIGH_BCD = 8'(((PRESET_HIGH / 10) << 4) | (PRESET_HIGH % 10));

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        min_t_q, min_u_q, sec_t_q, sec_u_q;
  logic [3:0]        min_t_d, min_u_d, sec_t_d, sec_u_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              done_q, done_d;
  logic              start_q;
  logic              start_edge;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        dig_q, dig_d;
  logic [3:0]        digit_sel;

  logic [7:0]        preset_bcd;
  logic              preset_zero;
  logic [3:0]        dec_min_t, dec_min_u, dec_sec_t, dec_sec_u;
  logic              borrow_st, borrow_mu, borrow_mt;
  logic              dec_zero;
  logic              tick_wrap;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    p = 7'b0000000;
    case (d)
      4'd0: p = 7'b1111110;
      4'd1: p = 7'b0110000;
      4'd2: p = 7'b1101101;
      4'd3: p = 7'b1111001;
      4'd4: p = 7'b0110011;
      4'd5: p = 7'b1011011;
      4'd6: p = 7'b1011111;
      4'd7: p = 7'b1110000;
      4'd8: p = 7'b1111111;
      4'd9: p = 7'b1111011;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  assign start_edge = tmr.start & ~start_q;
  assign tick_wrap  = (tick_q == TICK_LAST);

  always_comb begin
    preset_bcd = 8'h00;
    case (tmr.level)
      2'b01:   preset_bcd = LOW_BCD;
      2'b10:   preset_bcd = MED_BCD;
      2'b11:   preset_bcd = HIGH_BCD;
      default: preset_bcd = 8'h00;
    endcase
  end
  assign preset_zero = (preset_bcd == 8'h00);

  // One-second decrement with borrow rippling from seconds units up to minutes tens.
  assign borrow_st = (sec_u_q == 4'd0);
  assign borrow_mu = borrow_st && (sec_t_q == 4'd0);
  assign borrow_mt = borrow_mu && (min_u_q == 4'd0);

  assign dec_sec_u = borrow_st ? 4'd9 : sec_u_q - 4'd1;
  assign dec_sec_t = borrow_st ? ((sec_t_q == 4'd0) ? 4'd5 : sec_t_q - 4'd1) : sec_t_q;
  assign dec_min_u = borrow_mu ? ((min_u_q == 4'd0) ? 4'd9 : min_u_q - 4'd1) : min_u_q;
  assign dec_min_t = borrow_mt ? min_t_q - 4'd1 : min_t_q;
  assign dec_zero  = ({dec_min_t, dec_min_u, dec_sec_t, dec_sec_u} == 16'h0000);

  always_comb begin
    state_d = state_q;
    min_t_d = min_t_q;
    min_u_d = min_u_q;
    sec_t_d = sec_t_q;
    sec_u_d = sec_u_q;
    tick_d  = tick_q;
    done_d  = 1'b0;

    if (tmr.abort) begin
      state_d = IDLE;
      min_t_d = 4'd0;
      min_u_d = 4'd0;
      sec_t_d = 4'd0;
      sec_u_d = 4'd0;
      tick_d  = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_edge && (tmr.level != 2'b00)) begin
            min_t_d = preset_bcd[7:4];
            min_u_d = preset_bcd[3:0];
            sec_t_d = 4'd0;
            sec_u_d = 4'd0;
            tick_d  = '0;
            if (preset_zero) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (tmr.pause) begin
            state_d = PAUSE;
          end else if (tick_wrap) begin
            tick_d  = '0;
            min_t_d = dec_min_t;
            min_u_d = dec_min_u;
            sec_t_d = dec_sec_t;
            sec_u_d = dec_sec_u;
            if (dec_zero) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        PAUSE: begin
          if (!tmr.pause) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min_t_q <= 4'd0;
      min_u_q <= 4'd0;
      sec_t_q <= 4'd0;
      sec_u_q <= 4'd0;
      tick_q  <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_t_q <= min_t_d;
      min_u_q <= min_u_d;
      sec_t_q <= sec_t_d;
      sec_u_q <= sec_u_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      start_q <= tmr.start;
    end
  end

  // seg is decoded from next-state digits so it always shows the current count under dig_en.
  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
    idx_d  = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
    digit_sel = sec_u_d;
    case (idx_d)
      2'd0:    digit_sel = sec_u_d;
      2'd1:    digit_sel = sec_t_d;
      2'd2:    digit_sel = min_u_d;
      default: digit_sel = min_t_d;
    endcase
    seg_d = seg_decode(digit_sel);
    dig_d = 4'b0001 << idx_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
      seg_q  <= 7'b1111110;
      dig_q  <= 4'b0001;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
    end
  end

  assign tmr.state    = state_q;
  assign tmr.valve_en = (state_q == RUN);
  assign tmr.done     = done_q;
  assign tmr.min_bcd  = {min_t_q, min_u_q};
  assign tmr.sec_bcd  = {sec_t_q, sec_u_q};
  assign tmr.seg      = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign tmr.dig_en   = (SEG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// Bench for irrigation_countdown_timer: vector table, corner sequences and random traffic vs a seconds-based model.
module tb_irrigation_countdown_timer;
  localparam int TD = 4;
  localparam int SD = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  irrigation_countdown_timer_if tif();

  irrigation_countdown_timer #(
    .TICK_DIV(TD), .SCAN_DIV(SD), .PRESET_LOW(1), .PRESET_MED(0),
    .PRESET_HIGH(10), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tmr(tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining time kept as plain seconds, display derived from cycle count.
  int m_state, m_secs, m_tick, m_cycles;
  bit m_done, m_start_q;

  function automatic int preset_min(input logic [1:0] lv);
    case (lv)
      2'b01:   return 1;
      2'b10:   return 0;
      2'b11:   return 10;
      default: return 0;
    endcase
  endfunction

  function automatic logic [6:0] pat(input int d);
    logic [6:0] t [10];
    t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
          7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    return t[d];
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_tick = 0; m_cycles = 0; m_done = 0; m_start_q = 0;
  endtask

  task automatic model_tick();
    bit se;
    se = tif.start && !m_start_q;
    m_start_q = tif.start;
    m_done = 0;
    m_cycles++;
    if (tif.abort) begin
      m_state = 0; m_secs = 0; m_tick = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (se && tif.level != 2'b00) begin
        m_secs = preset_min(tif.level) * 60;
        m_tick = 0;
        if (m_secs == 0) begin m_state = 3; m_done = 1; end
        else m_state = 1;
      end
    end else if (m_state == 1) begin
      if (tif.pause) m_state = 2;
      else if (m_tick == TD - 1) begin
        m_tick = 0;
        m_secs--;
        if (m_secs == 0) begin m_state = 3; m_done = 1; end
      end else m_tick++;
    end else if (!tif.pause) begin
      m_state = 1;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int mm, ss, idx, dv;
    mm = m_secs / 60;
    ss = m_secs % 60;
    idx = (m_cycles / SD) % 4;
    case (idx)
      0:       dv = ss % 10;
      1:       dv = ss / 10;
      2:       dv = mm % 10;
      default: dv = mm / 10;
    endcase
    chk("m_state", 16'(tif.state), 16'(m_state));
    chk("m_valve", 16'(tif.valve_en), 16'(m_state == 1));
    chk("m_done", 16'(tif.done), 16'(m_done));
    chk("m_min", 16'(tif.min_bcd), 16'((mm / 10) * 16 + mm % 10));
    chk("m_sec", 16'(tif.sec_bcd), 16'((ss / 10) * 16 + ss % 10));
    chk("m_dig", 16'(tif.dig_en), 16'(1 << idx));
    chk("m_seg", 16'(tif.seg), 16'(pat(dv)));
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check_model();
  endtask

  task automatic drive(input logic [1:0] lv, input logic st, input logic pa, input logic ab);
    tif.level = lv; tif.start = st; tif.pause = pa; tif.abort = ab;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic [1:0] level;
    logic       start, pause, abort;
    logic [1:0] st;
    logic [7:0] mn, sc;
    logic       valve, done;
  } vec_t;

  vec_t vt [20];

  initial begin
    int done_cnt;
    bit found;
    logic [3:0] prev_dig;
    logic [3:0] exp_dig [4];
    logic [6:0] exp_seg [4];

    total = 0; bad = 0;
    vt[0]  = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{2'b10, 1'b1, 1'b0, 1'b0, 2'b11, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[3]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[4]  = '{2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[5]  = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[6]  = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[7]  = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[8]  = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 8'h59, 1'b1, 1'b0};
    vt[9]  = '{2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'h59, 1'b0, 1'b0};
    vt[10] = '{2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'h59, 1'b0, 1'b0};
    vt[11] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 8'h59, 1'b1, 1'b0};
    vt[12] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 8'h59, 1'b1, 1'b0};
    vt[13] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 8'h59, 1'b1, 1'b0};
    vt[14] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 8'h59, 1'b1, 1'b0};
    vt[15] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 8'h58, 1'b1, 1'b0};
    vt[16] = '{2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 8'h00, 8'h58, 1'b1, 1'b0};
    vt[17] = '{2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[18] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 8'h10, 8'h00, 1'b1, 1'b0};
    vt[19] = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0};
    exp_dig = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_seg = '{7'b1111111, 7'b1011011, 7'b1111011, 7'b1111110};

    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #23;
    chk("rst_state", 16'(tif.state), 16'h0);
    chk("rst_time", {tif.min_bcd, tif.sec_bcd}, 16'h0000);
    chk("rst_dig", 16'(tif.dig_en), 16'b0001);
    chk("rst_seg", 16'(tif.seg), 16'b1111110);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].level, vt[i].start, vt[i].pause, vt[i].abort);
      step();
      chk($sformatf("vec%0d_state", i), 16'(tif.state), 16'(vt[i].st));
      chk($sformatf("vec%0d_min", i), 16'(tif.min_bcd), 16'(vt[i].mn));
      chk($sformatf("vec%0d_sec", i), 16'(tif.sec_bcd), 16'(vt[i].sc));
      chk($sformatf("vec%0d_valve", i), 16'(tif.valve_en), 16'(vt[i].valve));
      chk($sformatf("vec%0d_done", i), 16'(tif.done), 16'(vt[i].done));
    end

    // Full one-minute run: done exactly once, on the 240th edge.
    drive(2'b01, 1'b1, 1'b0, 1'b0);
    step();
    chk("run_load", {tif.min_bcd, tif.sec_bcd}, 16'h0100);
    drive(2'b01, 1'b0, 1'b0, 1'b0);
    done_cnt = 0;
    for (int i = 1; i <= 240; i++) begin
      step();
      if (tif.done) done_cnt++;
      if (i == 4) chk("run_first_dec", 16'(tif.sec_bcd), 16'h59);
    end
    chk("run_done_last", 16'(tif.done), 16'h1);
    chk("run_done_cnt", 16'(done_cnt), 16'h1);
    chk("run_end_state", 16'(tif.state), 16'h3);
    step();
    chk("run_done_clear", 16'(tif.done), 16'h0);

    // Reload from DONE at level 11, full borrow chain, then pause one edge after a tick.
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    step();
    chk("reload", {tif.min_bcd, tif.sec_bcd}, 16'h1000);
    chk("reload_state", 16'(tif.state), 16'h1);
    drive(2'b11, 1'b0, 1'b0, 1'b0);
    steps(4);
    chk("borrow", {tif.min_bcd, tif.sec_bcd}, 16'h0959);
    steps(4);
    chk("at_0958", {tif.min_bcd, tif.sec_bcd}, 16'h0958);
    step();
    drive(2'b11, 1'b0, 1'b1, 1'b0);
    step();
    chk("paused", 16'(tif.state), 16'h2);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      prev_dig = tif.dig_en;
      step();
      if (tif.dig_en == 4'b0001 && prev_dig != 4'b0001) found = 1;
    end
    chk("scan_align", 16'(found), 16'h1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      chk($sformatf("scan_dig%0d", k), 16'(tif.dig_en), 16'(exp_dig[k / 2]));
      chk($sformatf("scan_seg%0d", k), 16'(tif.seg), 16'(exp_seg[k / 2]));
    end
    chk("pause_hold", {tif.min_bcd, tif.sec_bcd}, 16'h0958);
    drive(2'b11, 1'b0, 1'b0, 1'b0);
    step();
    steps(2);
    chk("resume_pre", 16'(tif.sec_bcd), 16'h58);
    step();
    chk("resume_dec", 16'(tif.sec_bcd), 16'h57);

    // Abort coinciding with the final tick suppresses done.
    drive(2'b11, 1'b0, 1'b0, 1'b1);
    step();
    drive(2'b01, 1'b1, 1'b0, 1'b0);
    step();
    drive(2'b01, 1'b0, 1'b0, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 239; i++) begin
      step();
      if (tif.done) done_cnt++;
    end
    chk("pre_final", {tif.min_bcd, tif.sec_bcd}, 16'h0001);
    drive(2'b01, 1'b0, 1'b0, 1'b1);
    step();
    if (tif.done) done_cnt++;
    chk("abort_final_state", 16'(tif.state), 16'h0);
    chk("abort_final_done", 16'(done_cnt), 16'h0);
    chk("abort_final_time", {tif.min_bcd, tif.sec_bcd}, 16'h0000);

    // Asynchronous reset mid-run.
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    step();
    drive(2'b11, 1'b0, 1'b0, 1'b0);
    steps(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 16'(tif.state), 16'h0);
    chk("arst_time", {tif.min_bcd, tif.sec_bcd}, 16'h0000);
    chk("arst_valve", 16'(tif.valve_en), 16'h0);
    chk("arst_done", 16'(tif.done), 16'h0);
    chk("arst_dig", 16'(tif.dig_en), 16'b0001);
    chk("arst_seg", 16'(tif.seg), 16'b1111110);
    model_reset();
    #2 rst_n = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irrigation_countdown_timer.md
# irrigation_countdown_timer

Parametrised MM:SS countdown timer for the irrigation valve controller, with preset durations selected by soil-moisture level, pause/resume, abort and a completion pulse. It is the next generation of the fixed-preset stopwatch path: tick divider, digit-scan divider and presets are parameters, and the count, FSM, scan multiplexer and 7-segment decoder sit in one block. It drives the valve enable and the 4-digit multiplexed display directly.

## Interface
- TICK_DIV, 50_000_000: clk cycles per 1 s decrement; must be ≥ 2.
- SCAN_DIV, 50_000: clk cycles per display digit advance; must be ≥ 1.
- PRESET_LOW, 4: minutes loaded for level 01; range 0..99.
- PRESET_MED, 8: minutes loaded for level 10; range 0..99.
- PRESET_HIGH, 12: minutes loaded for level 11; range 0..99.
- SEG_ACTIVE_LOW, 1: if 1, `seg` and `dig_en` are inverted at the output.
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- level  in  2  preset select: 00 none, 01 low, 10 med, 11 high.
- start  in  1  rising edge requests load and run.
- pause  in  1  level; high freezes the count in RUN.
- abort  in  1  level; returns to IDLE and clears the count.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- valve_en  out  1  high only in RUN.
- done  out  1  one-cycle pulse when the count reaches 00:00.
- min_bcd  out  8  {tens, units} of minutes, BCD.
- sec_bcd  out  8  {tens, units} of seconds, BCD; tens range 0..5.
- seg  out  7  {a,b,c,d,e,f,g} for the currently scanned digit.
- dig_en  out  4  one-hot digit select: bit0 sec units, bit1 sec tens, bit2 min units, bit3 min tens.

## Operation
- Start edge: start_edge = start & ~start_q. start_q resets to 0, so a start held high through reset produces an edge on the first clock after reset.
- IDLE, start_edge with level≠00: load min = preset and sec = 00, clear tick_cnt, go to RUN. If level = 00, the start is ignored.
- Preset 0: the load produces 00:00. The FSM goes straight to DONE and asserts done in that cycle.
- RUN: tick_cnt counts 0..TICK_DIV-1. At wrap, the count decrements by one second.
- Decrement rules, applied digit by digit with borrow:
  - sec units 0 → 9, borrow to sec tens.
  - sec tens 0 → 5, borrow to min units.
  - min units 0 → 9, borrow to min tens.
- A decrement that yields 00:00 goes to DONE and asserts done.
- RUN, pause high: go to PAUSE. tick_cnt and the count are held.
- PAUSE, pause low: return to RUN. tick_cnt resumes from its held value.
- DONE: the count holds 00:00. A start_edge with level≠00 reloads and goes to RUN.
- abort in any state: go to IDLE and clear the count to 00:00 and tick_cnt to 0.
- Priority: abort > pause > tick > start. If abort coincides with the final tick, there is no done pulse.
- start_edge in RUN or PAUSE is ignored.
- Scan: scan_cnt counts 0..SCAN_DIV-1. At wrap, digit index advances 0→1→2→3→0. Scanning runs in every state.
- seg: standard decode of the selected BCD digit (0..9), registered on the same edge as dig_en, so seg always matches dig_en. Active-high patterns are 0 = 1111110 and 1 = 0110000. Digit values above 9 are unreachable; decode them as blank.

## Timing
- Reset values:
  - state = IDLE, count 00:00, tick_cnt = 0, scan_cnt = 0, digit index = 0.
  - valve_en = 0, done = 0.
  - dig_en = 0001 and seg = pattern "0", both before polarity inversion.
- Start latency: state, min_bcd and sec_bcd update on the same clock edge that first samples start high (1 edge).
- First decrement occurs TICK_DIV edges after entry to RUN.
- done and the state change to DONE occur on the edge that writes 00:00.
- Pause and abort act on the edge at which they are sampled. While paused, no decrement ever occurs.
- Each digit is held SCAN_DIV cycles, so the full scan period is 4·SCAN_DIV cycles.

## Test plan
Bench parameters: TICK_DIV=4, SCAN_DIV=2, PRESET_LOW=1, PRESET_MED=0, PRESET_HIGH=10, SEG_ACTIVE_LOW=0.
- Reset: assert rst_n=0 mid-run → immediately state=00, 00:00, valve_en=0, done=0, dig_en=0001, seg=1111110.
- Level 01 start pulse → next edge 01:00, state=RUN, valve_en=1; 4 edges later 00:59; after 60 ticks (240 edges) 00:00, done high for exactly 1 cycle, state=DONE, valve_en=0.
- Level 11 start → 10:00; after the first tick 09:59 (full borrow chain); DONE then start → reload to 10:00, RUN.
- Pause 1 edge after a tick for 10 cycles → count and tick_cnt frozen, state=PAUSE, valve_en=0. Release → next decrement 3 edges later.
- Abort on the same edge as the 00:01→00:00 tick → IDLE, 00:00, done never asserted. Level 00 start → stays IDLE. Level 10 start → DONE with done pulse on the load edge.
- Pause at 09:58 → dig_en cycles 0001, 0010, 0100, 1000, 2 cycles each. seg = 8, 5, 9, 0 patterns (1111111, 1011011, 1111011, 1111110), each aligned with its dig_en.
